// File: rtl/memory_arbiter_ctrl.sv
// Cache-bus responder: arbitrates dcache and icache requests onto one single-port RAM.
// Optional ARB_RR_EN selects round-robin arbitration instead of fixed dcache priority.
module memory_arbiter_ctrl #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    output logic              ram_REN,
    output logic              ram_WEN,
    output logic [WORD_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_store,
    input  logic [WORD_W-1:0] ram_load,
    input  logic              ram_rdy,
    output logic              bus_err
);

    localparam logic [7:0]        TMO_MAX  = 8'(TIMEOUT);
    localparam logic [WORD_W-1:0] ERR_WORD = WORD_W'(32'hBAD1BAD1);

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t            state, next_state;
    logic [7:0]        tmo_cnt;
    logic              op_wr;
    logic              done, tmo_hit, grant_d, grant_i;
    logic              d_req, d_done, i_done;
    logic [WORD_W-1:0] rsp_data;
`ifdef ARB_RR_EN
    logic              last_grant;
`endif

    assign d_req = dREN | dWEN;

    always_comb begin
        next_state = state;
        done       = 1'b0;
        tmo_hit    = 1'b0;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        case (state)
            IDLE: begin
`ifdef ARB_RR_EN
                // On contention, favour whichever requester was not granted last.
                if (d_req && iREN) begin
                    if (last_grant == 1'b0) grant_i = 1'b1;
                    else                    grant_d = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end else if (iREN) begin
                    grant_i = 1'b1;
                end
`else
                if (d_req)     grant_d = 1'b1;
                else if (iREN) grant_i = 1'b1;
`endif
                if (grant_d)      next_state = DGRANT;
                else if (grant_i) next_state = IGRANT;
            end
            DGRANT, IGRANT: begin
                // A real ram_rdy wins over a coincident timeout.
                tmo_hit = !ram_rdy && (tmo_cnt == TMO_MAX);
                done    = ram_rdy | tmo_hit;
                if (done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign d_done   = done && (state == DGRANT);
    assign i_done   = done && (state == IGRANT);
    assign rsp_data = tmo_hit ? ERR_WORD : ram_load;
    assign dwait    = d_req & ~d_done;
    assign iwait    = iREN & ~i_done;
    assign dload    = (d_done && !op_wr) ? rsp_data : '0;
    assign iload    = i_done ? rsp_data : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            ram_REN    <= 1'b0;
            ram_WEN    <= 1'b0;
            ram_addr   <= '0;
            ram_store  <= '0;
            tmo_cnt    <= '0;
            bus_err    <= 1'b0;
            op_wr      <= 1'b0;
`ifdef ARB_RR_EN
            last_grant <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (grant_d) begin
                op_wr      <= dWEN;
                ram_REN    <= ~dWEN;
                ram_WEN    <= dWEN;
                ram_addr   <= daddr;
                ram_store  <= dstore;
                tmo_cnt    <= '0;
`ifdef ARB_RR_EN
                last_grant <= 1'b0;
`endif
            end else if (grant_i) begin
                op_wr      <= 1'b0;
                ram_REN    <= 1'b1;
                ram_WEN    <= 1'b0;
                ram_addr   <= iaddr;
                ram_store  <= '0;
                tmo_cnt    <= '0;
`ifdef ARB_RR_EN
                last_grant <= 1'b1;
`endif
            end else if (done) begin
                ram_REN <= 1'b0;
                ram_WEN <= 1'b0;
            end else if (state != IDLE && tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (tmo_hit) bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_arbiter_ctrl.sv
// Directed self-checking bench for memory_arbiter_ctrl.
module tb_memory_arbiter_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dREN, dWEN, iREN, ram_rdy;
    logic [31:0] daddr, dstore, iaddr, ram_load;
    logic        dwait, iwait, ram_REN, ram_WEN, bus_err;
    logic [31:0] dload, iload, ram_addr, ram_store;

    int checks = 0;
    int errors = 0;

    memory_arbiter_ctrl #(.WORD_W(32), .TIMEOUT(255)) dut (
        .CLK(CLK), .RST(RST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_rdy(ram_rdy),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic        stuck;
        logic [31:0] prev_addr;

        RST = 1'b1; dREN = 0; dWEN = 0; iREN = 0; ram_rdy = 0;
        daddr = '0; dstore = '0; iaddr = '0; ram_load = '0;
        step(); step();
        chk1 ("rst_ren",   ram_REN,   1'b0);
        chk1 ("rst_wen",   ram_WEN,   1'b0);
        chk32("rst_addr",  ram_addr,  32'h0);
        chk32("rst_store", ram_store, 32'h0);
        chk1 ("rst_err",   bus_err,   1'b0);
        chk1 ("rst_dwait", dwait,     1'b0);
        chk1 ("rst_iwait", iwait,     1'b0);

        // ram_rdy while idle must do nothing
        RST = 1'b0; ram_rdy = 1'b1; ram_load = 32'h1234;
        step();
        chk1 ("idle_rdy_ren", ram_REN, 1'b0);
        chk32("idle_rdy_dld", dload,   32'h0);
        ram_rdy = 1'b0;

        // dcache read, ram_rdy three cycles after the strobe
        dREN = 1'b1; daddr = 32'h100; #1;
        chk1 ("rd_wait_req", dwait, 1'b1);
        step();
        chk1 ("rd_ren",   ram_REN,  1'b1);
        chk1 ("rd_wen",   ram_WEN,  1'b0);
        chk32("rd_addr",  ram_addr, 32'h100);
        chk1 ("rd_wait1", dwait,    1'b1);
        step();
        chk1 ("rd_wait2", dwait, 1'b1);
        step();
        chk1 ("rd_wait3", dwait, 1'b1);
        step();
        ram_rdy = 1'b1; ram_load = 32'hDEADBEEF; #1;
        chk1 ("rd_done_wait", dwait, 1'b0);
        chk32("rd_done_load", dload, 32'hDEADBEEF);
        step();
        ram_rdy = 1'b0; dREN = 1'b0; #1;
        chk1 ("rd_idle_ren",  ram_REN, 1'b0);
        chk32("rd_idle_load", dload,   32'h0);

        // dcache write
        dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h5;
        step();
        chk1 ("wr_wen",   ram_WEN,   1'b1);
        chk1 ("wr_ren",   ram_REN,   1'b0);
        chk32("wr_addr",  ram_addr,  32'h3100);
        chk32("wr_store", ram_store, 32'h5);
        chk1 ("wr_wait",  dwait,     1'b1);
        ram_rdy = 1'b1; ram_load = 32'hFFFF0000; #1;
        chk1 ("wr_done_wait", dwait, 1'b0);
        chk32("wr_done_load", dload, 32'h0);
        step();
        dWEN = 1'b0; ram_rdy = 1'b0; #1;
        chk1 ("wr_idle_wen", ram_WEN, 1'b0);

        // both request continuously, RAM answers every strobe cycle
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h400;
        ram_rdy = 1'b1; ram_load = 32'h0000CAFE;
        prev_addr = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("arb_strobe", ram_REN, 1'b1);
`ifdef ARB_RR_EN
            if (k > 0) chk1("arb_alternate", ram_addr != prev_addr, 1'b1);
            prev_addr = ram_addr;
`else
            chk32("arb_addr",  ram_addr, 32'h200);
            chk1 ("arb_dwait", dwait,    1'b0);
            chk1 ("arb_iwait", iwait,    1'b1);
            chk32("arb_dload", dload,    32'h0000CAFE);
`endif
            step();
            chk1("arb_idle_gap", ram_REN, 1'b0);
        end
        dREN = 1'b0; iREN = 1'b0; ram_rdy = 1'b0;
        step();

        // icache read that never completes: forced timeout
        iREN = 1'b1; iaddr = 32'h40;
        step();
        chk1 ("tmo_ren",  ram_REN,  1'b1);
        chk32("tmo_addr", ram_addr, 32'h40);
        stuck = 1'b1;
        repeat (255) begin
            if (iwait !== 1'b1) stuck = 1'b0;
            step();
        end
        chk1 ("tmo_held_255", stuck, 1'b1);
        chk1 ("tmo_iwait",    iwait, 1'b0);
        chk32("tmo_iload",    iload, 32'hBAD1BAD1);
        chk1 ("tmo_err_pre",  bus_err, 1'b0);
        step();
        iREN = 1'b0; #1;
        chk1 ("tmo_err",     bus_err, 1'b1);
        chk1 ("tmo_ren_off", ram_REN, 1'b0);
        step(); step();
        chk1 ("tmo_err_sticky", bus_err, 1'b1);

        // dcache drops its request one cycle into the grant
        dREN = 1'b1; daddr = 32'h500;
        step();
        chk1 ("drop_ren", ram_REN, 1'b1);
        dREN = 1'b0; #1;
        chk1 ("drop_wait0", dwait, 1'b0);
        step();
        chk1 ("drop_ren_held", ram_REN, 1'b1);
        chk1 ("drop_wait1",    dwait,   1'b0);
        ram_rdy = 1'b1; #1;
        chk1 ("drop_wait_done", dwait, 1'b0);
        step();
        ram_rdy = 1'b0; dREN = 1'b1; daddr = 32'h600; #1;
        chk1 ("drop_idle_ren", ram_REN, 1'b0);
        chk1 ("next_wait",     dwait,   1'b1);
        step();
        chk1 ("next_ren",  ram_REN,  1'b1);
        chk32("next_addr", ram_addr, 32'h600);

        // reset while in DGRANT
        RST = 1'b1;
        step();
        chk1 ("midrst_ren", ram_REN, 1'b0);
        chk1 ("midrst_wen", ram_WEN, 1'b0);
        chk1 ("midrst_err", bus_err, 1'b0);
        RST = 1'b0; dREN = 1'b0; ram_rdy = 1'b1; #1;
        chk32("midrst_no_done", dload, 32'h0);
        step();
        chk1 ("postrst_idle", ram_REN, 1'b0);
        ram_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
